// File: rtl/ring_router_node_p_if.sv
// rtl/ring_router_node_p_if.sv - cw/ccw/pe send/data/ready bundle for the ring router node
interface ring_router_node_p_if #(
    parameter int DATA_W = 64
);
    logic              cwsi;
    logic [DATA_W-1:0] cwdi;
    logic              cwri;
    logic              cwso;
    logic [DATA_W-1:0] cwdo;
    logic              cwro;

    logic              ccwsi;
    logic [DATA_W-1:0] ccwdi;
    logic              ccwri;
    logic              ccwso;
    logic [DATA_W-1:0] ccwdo;
    logic              ccwro;

    logic              pesi;
    logic [DATA_W-1:0] pedi;
    logic              peri;
    logic              peso;
    logic [DATA_W-1:0] pedo;
    logic              pero;

    modport master (
        output cwsi, cwdi, cwro, ccwsi, ccwdi, ccwro, pesi, pedi, pero,
        input  cwri, cwso, cwdo, ccwri, ccwso, ccwdo, peri, peso, pedo
    );

    modport slave (
        input  cwsi, cwdi, cwro, ccwsi, ccwdi, ccwro, pesi, pedi, pero,
        output cwri, cwso, cwdo, ccwri, ccwso, ccwdo, peri, peso, pedo
    );
endinterface

// File: rtl/ring_router_node_p.sv
// rtl/ring_router_node_p.sv - 2-VC bidirectional ring router node with per-VC input FIFOs
// Optional delivered-packet counters enabled by ROUTER_PERF_CNT_EN.
module ring_router_node_p #(
    parameter int DATA_W    = 64,
    parameter int HOP_W     = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        polarity,
    ring_router_node_p_if.slave bus,
    output logic [15:0] cnt_cw,
    output logic [15:0] cnt_ccw,
    output logic [15:0] cnt_pe
);
    localparam int VC_BIT  = DATA_W - 1;
    localparam int DIR_BIT = DATA_W - 2;
    localparam int HOP_MSB = DATA_W - 9;
    localparam int HOP_LSB = DATA_W - 8 - HOP_W;
    localparam int PW      = $clog2(BUF_DEPTH);
    localparam int CW      = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    // Port index 0 = cw, 1 = ccw, 2 = pe (for both inputs and outputs).
    logic [2:0]        in_send;
    logic [2:0]        out_ready;
    logic [DATA_W-1:0] in_data [3];

    logic [DATA_W-1:0] mem_q [3][2][BUF_DEPTH];
    logic [PW-1:0]     rd_q  [3][2];
    logic [PW-1:0]     wr_q  [3][2];
    logic [CW-1:0]     cnt_q [3][2];
    logic [CW-1:0]     cnt_d [3][2];
    logic [2:0][1:0]   push;
    logic [2:0][1:0]   pop;

    logic              pol_q;
    logic [2:0]        ri_q, ri_d;
    logic [2:0]        so_q, so_d;
    logic [2:0]        rr_q, rr_d;
    logic [DATA_W-1:0] do_q [3];
    logic [DATA_W-1:0] do_d [3];

    logic [DATA_W-1:0] head [3];
    logic [2:0]        hv;
    logic [2:0]        req_a, req_b, ga, gb, pop_any;
    logic [DATA_W-1:0] pkt_a [3];
    logic [DATA_W-1:0] pkt_b [3];

    function automatic logic [DATA_W-1:0] hop_shift(input logic [DATA_W-1:0] p);
        logic [DATA_W-1:0] r;
        r = p;
        r[HOP_MSB -: HOP_W] = p[HOP_MSB -: HOP_W] >> 1;
        return r;
    endfunction

    assign in_send    = {bus.pesi, bus.ccwsi, bus.cwsi};
    assign out_ready  = {bus.pero, bus.ccwro, bus.cwro};
    assign in_data[0] = bus.cwdi;
    assign in_data[1] = bus.ccwdi;
    assign in_data[2] = bus.pedi;

    always_comb begin
        push    = '0;
        pop     = '0;
        ga      = '0;
        gb      = '0;
        so_d    = '0;
        rr_d    = rr_q;
        pop_any = '0;
        for (int i = 0; i < 3; i++) begin
            head[i] = mem_q[i][pol_q][rd_q[i][pol_q]];
            hv[i]   = (cnt_q[i][pol_q] != '0);
        end
        // Side a is always a ring input so a cleared pointer favours the ring.
        req_a[0] = hv[0] &&  head[0][HOP_LSB];
        req_b[0] = hv[2] && !head[2][DIR_BIT];
        pkt_a[0] = hop_shift(head[0]);
        pkt_b[0] = hop_shift(head[2]);
        req_a[1] = hv[1] &&  head[1][HOP_LSB];
        req_b[1] = hv[2] &&  head[2][DIR_BIT];
        pkt_a[1] = hop_shift(head[1]);
        pkt_b[1] = hop_shift(head[2]);
        req_a[2] = hv[0] && !head[0][HOP_LSB];
        req_b[2] = hv[1] && !head[1][HOP_LSB];
        pkt_a[2] = head[0];
        pkt_b[2] = head[1];
        for (int o = 0; o < 3; o++) begin
            if (out_ready[o]) begin
                if (req_a[o] && req_b[o]) begin
                    ga[o]   = ~rr_q[o];
                    gb[o]   =  rr_q[o];
                    rr_d[o] = ~rr_q[o];
                end else begin
                    ga[o] = req_a[o];
                    gb[o] = req_b[o];
                end
            end
            so_d[o] = ga[o] | gb[o];
            do_d[o] = ga[o] ? pkt_a[o] : (gb[o] ? pkt_b[o] : '0);
        end
        pop_any[0] = ga[0] | ga[2];
        pop_any[1] = ga[1] | gb[2];
        pop_any[2] = gb[0] | gb[1];
        for (int i = 0; i < 3; i++) begin
            for (int v = 0; v < 2; v++) begin
                pop[i][v]  = pop_any[i] && (pol_q == v[0]);
                push[i][v] = in_send[i] && (in_data[i][VC_BIT] == v[0]) && (cnt_q[i][v] != FULL);
                cnt_d[i][v] = cnt_q[i][v] + {{(CW-1){1'b0}}, push[i][v]}
                                          - {{(CW-1){1'b0}}, pop[i][v]};
            end
            ri_d[i] = (cnt_d[i][0] != FULL) && (cnt_d[i][1] != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pol_q <= 1'b0;
            ri_q  <= '0;
            so_q  <= '0;
            rr_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                do_q[i] <= '0;
                for (int v = 0; v < 2; v++) begin
                    rd_q[i][v]  <= '0;
                    wr_q[i][v]  <= '0;
                    cnt_q[i][v] <= '0;
                end
            end
        end else begin
            pol_q <= ~pol_q;
            ri_q  <= ri_d;
            so_q  <= so_d;
            rr_q  <= rr_d;
            for (int i = 0; i < 3; i++) begin
                do_q[i] <= do_d[i];
                for (int v = 0; v < 2; v++) begin
                    cnt_q[i][v] <= cnt_d[i][v];
                    if (push[i][v]) wr_q[i][v] <= wr_q[i][v] + 1'b1;
                    if (pop[i][v])  rd_q[i][v] <= rd_q[i][v] + 1'b1;
                end
            end
        end
    end

    // Payload storage needs no reset; occupancy counters define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int v = 0; v < 2; v++) begin
                if (reset_n && push[i][v]) mem_q[i][v][wr_q[i][v]] <= in_data[i];
            end
        end
    end

    assign polarity  = pol_q;
    assign bus.cwri  = ri_q[0];
    assign bus.ccwri = ri_q[1];
    assign bus.peri  = ri_q[2];
    assign bus.cwso  = so_q[0];
    assign bus.ccwso = so_q[1];
    assign bus.peso  = so_q[2];
    assign bus.cwdo  = do_q[0];
    assign bus.ccwdo = do_q[1];
    assign bus.pedo  = do_q[2];

`ifdef ROUTER_PERF_CNT_EN
    logic [15:0] pc_q [3];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int o = 0; o < 3; o++) pc_q[o] <= '0;
        end else begin
            for (int o = 0; o < 3; o++) begin
                if (so_d[o] && pc_q[o] != 16'hFFFF) pc_q[o] <= pc_q[o] + 16'd1;
            end
        end
    end

    assign cnt_cw  = pc_q[0];
    assign cnt_ccw = pc_q[1];
    assign cnt_pe  = pc_q[2];
`else
    assign cnt_cw  = 16'h0;
    assign cnt_ccw = 16'h0;
    assign cnt_pe  = 16'h0;
`endif
endmodule

// File: tb/tb_ring_router_node_p.sv
// tb/tb_ring_router_node_p.sv - directed plus random bench for ring_router_node_p against a queue model
module tb_ring_router_node_p;
    localparam int DATA_W    = 64;
    localparam int HOP_W     = 8;
    localparam int BUF_DEPTH = 2;
    localparam int HOP_LSB   = DATA_W - 8 - HOP_W;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        polarity;
    logic [15:0] cnt_cw, cnt_ccw, cnt_pe;

    logic [2:0]  si, ro;
    logic [63:0] di [3];

    ring_router_node_p_if #(.DATA_W(DATA_W)) bus ();

    assign bus.cwsi  = si[0];
    assign bus.ccwsi = si[1];
    assign bus.pesi  = si[2];
    assign bus.cwdi  = di[0];
    assign bus.ccwdi = di[1];
    assign bus.pedi  = di[2];
    assign bus.cwro  = ro[0];
    assign bus.ccwro = ro[1];
    assign bus.pero  = ro[2];

    ring_router_node_p #(
        .DATA_W(DATA_W), .HOP_W(HOP_W), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .polarity(polarity), .bus(bus),
        .cnt_cw(cnt_cw), .cnt_ccw(cnt_ccw), .cnt_pe(cnt_pe)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queues per input port and VC, expected registered outputs.
    logic [63:0] mq [3][2][$];
    bit          m_pol;
    bit   [2:0]  m_ptr;
    bit   [2:0]  e_so, e_ri;
    logic [63:0] e_do [3];
    int          e_cnt [3];

    function automatic logic [63:0] hop_dec(input logic [63:0] p);
        logic [63:0] hop;
        hop = (p >> HOP_LSB) & 64'hFF;
        return (p & ~(64'hFF << HOP_LSB)) | ((hop / 2) << HOP_LSB);
    endfunction

    function automatic logic [63:0] mk(input bit vc, input bit dir, input logic [7:0] hop,
                                       input logic [31:0] pay);
        return {vc, dir, 6'b0, hop, 16'h0, pay};
    endfunction

    task automatic model_step();
        if (!reset_n) begin
            m_pol = 0;
            m_ptr = '0;
            e_so  = '0;
            e_ri  = '0;
            for (int i = 0; i < 3; i++) begin
                e_do[i] = '0;
                e_cnt[i] = 0;
                for (int v = 0; v < 2; v++) mq[i][v].delete();
            end
        end else begin
            bit has [3];
            int dest [3];
            logic [63:0] hd [3];
            bit popped [3];
            bit acc [3];
            for (int i = 0; i < 3; i++) begin
                popped[i] = 0;
                has[i] = mq[i][m_pol].size() > 0;
                hd[i] = has[i] ? mq[i][m_pol][0] : 64'h0;
                if (i == 2) dest[i] = hd[i][62] ? 1 : 0;
                else        dest[i] = (((hd[i] >> HOP_LSB) % 2) == 1) ? i : 2;
            end
            for (int o = 0; o < 3; o++) begin
                int a, b, win;
                bit wa, wb;
                a = (o == 2) ? 0 : o;
                b = (o == 2) ? 1 : 2;
                wa = has[a] && dest[a] == o;
                wb = has[b] && dest[b] == o;
                win = -1;
                if (ro[o]) begin
                    if (wa && wb) begin
                        win = m_ptr[o] ? b : a;
                        m_ptr[o] = ~m_ptr[o];
                    end else if (wa) win = a;
                    else if (wb) win = b;
                end
                e_so[o] = (win >= 0);
                e_do[o] = 64'h0;
                if (win >= 0) begin
                    e_do[o] = (o == 2) ? hd[win] : hop_dec(hd[win]);
                    popped[win] = 1;
`ifdef ROUTER_PERF_CNT_EN
                    if (e_cnt[o] < 65535) e_cnt[o]++;
`endif
                end
            end
            for (int i = 0; i < 3; i++)
                acc[i] = si[i] && mq[i][di[i][63]].size() < BUF_DEPTH;
            for (int i = 0; i < 3; i++) begin
                if (popped[i]) void'(mq[i][m_pol].pop_front());
                if (acc[i]) mq[i][di[i][63]].push_back(di[i]);
                e_ri[i] = mq[i][0].size() < BUF_DEPTH && mq[i][1].size() < BUF_DEPTH;
            end
            m_pol = ~m_pol;
        end
    endtask

    task automatic tick();
        logic [2:0]  so_w;
        logic [2:0]  ri_w;
        logic [63:0] do_w [3];
        logic [15:0] cn_w [3];
        model_step();
        @(negedge clk);
        so_w = {bus.peso, bus.ccwso, bus.cwso};
        ri_w = {bus.peri, bus.ccwri, bus.cwri};
        do_w[0] = bus.cwdo;  do_w[1] = bus.ccwdo;  do_w[2] = bus.pedo;
        cn_w[0] = cnt_cw;    cn_w[1] = cnt_ccw;    cn_w[2] = cnt_pe;
        chk("polarity", {63'h0, polarity}, {63'h0, m_pol});
        for (int o = 0; o < 3; o++) begin
            chk($sformatf("so%0d", o), {63'h0, so_w[o]}, {63'h0, e_so[o]});
            chk($sformatf("do%0d", o), do_w[o], e_do[o]);
            chk($sformatf("ri%0d", o), {63'h0, ri_w[o]}, {63'h0, e_ri[o]});
            chk($sformatf("cnt%0d", o), {48'h0, cn_w[o]}, 64'(e_cnt[o]));
        end
    endtask

    task automatic idle(input int n);
        si = '0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send(input int port, input logic [63:0] pkt);
        si = '0;
        si[port] = 1'b1;
        di[port] = pkt;
        tick();
        si = '0;
    endtask

    initial begin
        si = '0;
        ro = 3'b111;
        for (int i = 0; i < 3; i++) di[i] = '0;
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        reset_n = 1'b1;
        idle(3);

        send(2, mk(0, 0, 8'h03, 32'hA5A50001));
        idle(3);
        send(0, mk(1, 0, 8'h00, 32'h0000BEEF));
        idle(3);

        si = 3'b101;
        di[0] = mk(0, 0, 8'h01, 32'h11110000);
        di[2] = mk(0, 0, 8'h05, 32'h22220000);
        tick();
        idle(5);

        ro[0] = 1'b0;
        for (int k = 0; k < BUF_DEPTH + 1; k++) send(2, mk(0, 0, 8'h0F, 32'h3000 + k));
        idle(3);
        ro[0] = 1'b1;
        idle(8);

        for (int k = 0; k < 5; k++) send(0, mk(0, 0, 8'h00, 32'h5000 + k));
        idle(6);

        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 399) != 0);
            for (int i = 0; i < 3; i++) begin
                logic [7:0] hop;
                ro[i] = ($urandom_range(0, 9) < 7);
                si[i] = ($urandom_range(0, 2) != 0);
                hop = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
                di[i] = {1'($urandom), 1'($urandom), 6'($urandom), hop, 16'($urandom), 32'($urandom)};
            end
            tick();
        end
        reset_n = 1'b1;
        ro = 3'b111;
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
